vending_machine_param: RTL and testbench

//  Parametrised single-product vending controller with coin entry, cancel/refund
//  and serial change dispensing, one coin per cycle.

---
 rtl/vending_machine_param_if.sv | 37 +++
 rtl/vending_machine_param.sv | 129 ++++++++++++
 tb/tb_vending_machine_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vending_machine_param_if.sv
// Coin-mech / dispenser bus for vending_machine_param.
//   master: coin-mech front end and dispenser side (drives coins and cancel,
//           observes vend, change and status)
//   slave : the vending controller
// Signals:
//   nickel_i, dime_i, quarter_i : coin present levels; a rising edge is one coin
//   cancel_i                    : refund request level; a rising edge is a request
//   soda_o                      : vend pulse, one cycle per product
//   change_valid_o              : change_coin_o holds a coin to eject this cycle
//   change_coin_o               : 01 nickel, 10 dime, 00 none
//   credit_o                    : current credit in cents
//   busy_o                      : vending or paying change; coins are refused
//   coin_reject_o               : one-cycle pulse, a coin edge was refused
interface vending_machine_param_if #(
  parameter int CREDIT_W = 7
);
  logic                nickel_i;
  logic                dime_i;
  logic                quarter_i;
  logic                cancel_i;
  logic                soda_o;
  logic                change_valid_o;
  logic [1:0]          change_coin_o;
  logic [CREDIT_W-1:0] credit_o;
  logic                busy_o;
  logic                coin_reject_o;

  modport master (
    output nickel_i, dime_i, quarter_i, cancel_i,
    input  soda_o, change_valid_o, change_coin_o, credit_o, busy_o, coin_reject_o
  );

  modport slave (
    input  nickel_i, dime_i, quarter_i, cancel_i,
    output soda_o, change_valid_o, change_coin_o, credit_o, busy_o, coin_reject_o
  );
endinterface

// File: rtl/vending_machine_param.sv
// Single-product vending controller. Takes coin strobes, tracks credit, vends
// once credit reaches PRICE, then pays change or a cancel refund as a serial
// stream of dimes/nickels, one coin per cycle.
// Ports:
//   clk_i    : clock, rising edge
//   reset_ni : asynchronous active-low reset
//   bus      : vending_machine_param_if.slave (coins, cancel, vend, change,
//              credit, busy, coin reject)
// All outputs are decoded from registered state, so an event sampled at edge
// k shows up on the outputs right after edge k.
module vending_machine_param #(
  parameter int PRICE       = 20,
  parameter int NICKEL_VAL  = 5,
  parameter int DIME_VAL    = 10,
  parameter int QUARTER_VAL = 25,
  parameter int MAX_CREDIT  = 95,
  parameter int CREDIT_W    = 7
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  vending_machine_param_if.slave  bus
);
  localparam int AW = CREDIT_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_CHANGE  = 2'd3;

  localparam logic [AW-1:0] PRICE_A   = AW'(PRICE);
  localparam logic [AW-1:0] NICKEL_A  = AW'(NICKEL_VAL);
  localparam logic [AW-1:0] DIME_A    = AW'(DIME_VAL);
  localparam logic [AW-1:0] QUARTER_A = AW'(QUARTER_VAL);
  localparam logic [AW-1:0] MAX_A     = AW'(MAX_CREDIT);

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b10;

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;
  // Edge history, ordered {quarter, dime, nickel}. Cleared on reset so a level
  // held through reset counts as one coin on release.
  logic [2:0]          coin_q;
  logic                cancel_q;

  logic [2:0]    coin_now, ev;
  logic          ev_cancel, ev_any, ev_multi;
  logic [AW-1:0] credit_a, coin_val, sum, step, remain, vend_left;

  assign coin_now  = {bus.quarter_i, bus.dime_i, bus.nickel_i};
  assign ev        = coin_now & ~coin_q;
  assign ev_cancel = bus.cancel_i & ~cancel_q;
  assign ev_any    = |ev;
  // More than one coin edge in the same cycle: all but the top one are refused.
  assign ev_multi  = (ev & (ev - 3'd1)) != 3'd0;
  assign credit_a  = {1'b0, credit_q};

  always_comb begin
    coin_val = '0;
    if (ev[2])      coin_val = QUARTER_A;
    else if (ev[1]) coin_val = DIME_A;
    else if (ev[0]) coin_val = NICKEL_A;
  end

  assign sum       = credit_a + coin_val;
  assign vend_left = credit_a - PRICE_A;
  assign step      = (credit_a >= DIME_A) ? DIME_A : NICKEL_A;
  // Saturate at zero so a credit that is not a nickel multiple still ends.
  assign remain    = (credit_a <= step) ? '0 : (credit_a - step);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        // Cancel only acts in COLLECT; in IDLE it is ignored and coins proceed.
        if (ev_cancel && state_q == S_COLLECT) begin
          state_d  = S_CHANGE;
          reject_d = ev_any;
        end else if (ev_any) begin
          reject_d = ev_multi;
          if (sum <= MAX_A) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = (sum >= PRICE_A) ? S_VEND : S_COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_VEND: begin
        reject_d = ev_any;
        credit_d = vend_left[CREDIT_W-1:0];
        state_d  = (vend_left == '0) ? S_IDLE : S_CHANGE;
      end
      default: begin // S_CHANGE
        reject_d = ev_any;
        credit_d = remain[CREDIT_W-1:0];
        state_d  = (remain == '0) ? S_IDLE : S_CHANGE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
      coin_q   <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
      coin_q   <= coin_now;
      cancel_q <= bus.cancel_i;
    end
  end

  assign bus.soda_o         = (state_q == S_VEND);
  assign bus.change_valid_o = (state_q == S_CHANGE);
  assign bus.change_coin_o  = (state_q != S_CHANGE) ? COIN_NONE :
                              (credit_a >= DIME_A)   ? COIN_DIME : COIN_NICKEL;
  assign bus.credit_o       = credit_q;
  assign bus.busy_o         = (state_q == S_VEND) || (state_q == S_CHANGE);
  assign bus.coin_reject_o  = reject_q;
endmodule

// File: tb/tb_vending_machine_param.sv
module tb_vending_machine_param;
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  int checks = 0;
  int failures = 0;

  // {soda, change_valid, change_coin[1:0], credit[6:0], busy, coin_reject}
  logic [12:0] exp_q[$];

  vending_machine_param_if #(.CREDIT_W(7)) bus();

  vending_machine_param dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input logic s, input logic cv, input logic [1:0] coin,
                            input int cr, input logic busy, input logic rej);
    exp_q.push_back({s, cv, coin, 7'(cr), busy, rej});
  endtask

  task automatic check(input string tag);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {bus.soda_o, bus.change_valid_o, bus.change_coin_o, bus.credit_o,
           bus.busy_o, bus.coin_reject_o};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed %h with empty scoreboard", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // Drive input levels, clock once, sample 1 time unit after the edge.
  task automatic cyc(input logic n, input logic d, input logic q, input logic c,
                     input string tag);
    bus.nickel_i  = n;
    bus.dime_i    = d;
    bus.quarter_i = q;
    bus.cancel_i  = c;
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    bus.nickel_i = 0; bus.dime_i = 0; bus.quarter_i = 0; bus.cancel_i = 0;
    #1;
    expect_out(0, 0, 2'b00, 0, 0, 0); check("reset");
    #2 reset_ni = 1'b1;

    // 1: four nickels -> vend, no change
    expect_out(0, 0, 2'b00, 5, 0, 0);  cyc(1, 0, 0, 0, "t1_n1");
    expect_out(0, 0, 2'b00, 5, 0, 0);  cyc(0, 0, 0, 0, "t1_n1_low");
    expect_out(0, 0, 2'b00, 10, 0, 0); cyc(1, 0, 0, 0, "t1_n2");
    expect_out(0, 0, 2'b00, 10, 0, 0); cyc(0, 0, 0, 0, "t1_n2_low");
    expect_out(0, 0, 2'b00, 15, 0, 0); cyc(1, 0, 0, 0, "t1_n3");
    expect_out(0, 0, 2'b00, 15, 0, 0); cyc(0, 0, 0, 0, "t1_n3_low");
    expect_out(1, 0, 2'b00, 20, 1, 0); cyc(1, 0, 0, 0, "t1_vend");
    expect_out(0, 0, 2'b00, 0, 0, 0);  cyc(0, 0, 0, 0, "t1_idle");

    // 2: quarter -> vend, nickel change
    expect_out(1, 0, 2'b00, 25, 1, 0); cyc(0, 0, 1, 0, "t2_vend");
    expect_out(0, 1, 2'b01, 5, 1, 0);  cyc(0, 0, 0, 0, "t2_nickel");
    expect_out(0, 0, 2'b00, 0, 0, 0);  cyc(0, 0, 0, 0, "t2_idle");

    // 3: dime + quarter = 35 -> vend, dime, nickel
    expect_out(0, 0, 2'b00, 10, 0, 0); cyc(0, 1, 0, 0, "t3_dime");
    expect_out(0, 0, 2'b00, 10, 0, 0); cyc(0, 0, 0, 0, "t3_dime_low");
    expect_out(1, 0, 2'b00, 35, 1, 0); cyc(0, 0, 1, 0, "t3_vend");
    expect_out(0, 1, 2'b10, 15, 1, 0); cyc(0, 0, 0, 0, "t3_chg_dime");
    expect_out(0, 1, 2'b01, 5, 1, 0);  cyc(0, 0, 0, 0, "t3_chg_nickel");
    expect_out(0, 0, 2'b00, 0, 0, 0);  cyc(0, 0, 0, 0, "t3_idle");

    // 4: dime then cancel -> dime refunded; cancel in IDLE does nothing
    expect_out(0, 0, 2'b00, 10, 0, 0); cyc(0, 1, 0, 0, "t4_dime");
    expect_out(0, 0, 2'b00, 10, 0, 0); cyc(0, 0, 0, 0, "t4_dime_low");
    expect_out(0, 1, 2'b10, 10, 1, 0); cyc(0, 0, 0, 1, "t4_refund");
    expect_out(0, 0, 2'b00, 0, 0, 0);  cyc(0, 0, 0, 0, "t4_idle");
    expect_out(0, 0, 2'b00, 0, 0, 0);  cyc(0, 0, 0, 1, "t4_cancel_idle");
    expect_out(0, 0, 2'b00, 0, 0, 0);  cyc(0, 0, 0, 0, "t4_cancel_idle_low");

    // 5: coin during CHANGE is refused, stream unchanged
    expect_out(1, 0, 2'b00, 25, 1, 0); cyc(0, 0, 1, 0, "t5_vend");
    expect_out(0, 1, 2'b01, 5, 1, 0);  cyc(0, 0, 0, 0, "t5_nickel");
    expect_out(0, 0, 2'b00, 0, 0, 1);  cyc(0, 1, 0, 0, "t5_busy_reject");
    expect_out(0, 0, 2'b00, 0, 0, 0);  cyc(0, 0, 0, 0, "t5_reject_clear");
    // dime + nickel together: dime accepted, nickel refused
    expect_out(0, 0, 2'b00, 10, 0, 1); cyc(1, 1, 0, 0, "t5_multi");
    expect_out(0, 0, 2'b00, 10, 0, 0); cyc(0, 0, 0, 0, "t5_multi_low");
    expect_out(0, 1, 2'b10, 10, 1, 0); cyc(0, 0, 0, 1, "t5_refund");
    expect_out(0, 0, 2'b00, 0, 0, 0);  cyc(0, 0, 0, 0, "t5_idle");
    // cancel and coin together in COLLECT: cancel wins, coin refused
    expect_out(0, 0, 2'b00, 5, 0, 0);  cyc(1, 0, 0, 0, "t5_n");
    expect_out(0, 0, 2'b00, 5, 0, 0);  cyc(0, 0, 0, 0, "t5_n_low");
    expect_out(0, 1, 2'b01, 5, 1, 1);  cyc(0, 1, 0, 1, "t5_cancel_wins");
    expect_out(0, 0, 2'b00, 0, 0, 0);  cyc(0, 0, 0, 0, "t5_cancel_idle");

    // 6: async reset during CHANGE, then nickel held across reset
    expect_out(1, 0, 2'b00, 25, 1, 0); cyc(0, 0, 1, 0, "t6_vend");
    expect_out(0, 1, 2'b01, 5, 1, 0);  cyc(0, 0, 0, 0, "t6_change");
    #2 reset_ni = 1'b0;
    #1;
    expect_out(0, 0, 2'b00, 0, 0, 0);  check("t6_async_reset");
    bus.nickel_i = 1'b1;
    #2 reset_ni = 1'b1;
    expect_out(0, 0, 2'b00, 5, 0, 0);  cyc(1, 0, 0, 0, "t6_held_nickel");
    expect_out(0, 0, 2'b00, 5, 0, 0);  cyc(1, 0, 0, 0, "t6_held_once");
    expect_out(0, 0, 2'b00, 5, 0, 0);  cyc(0, 0, 0, 0, "t6_release");

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 required", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
